// File: rtl/general_reg_file_pkg.sv
// Shared definitions for the general register file: datapath width, register
// count, register-id type and small id helpers.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package general_reg_file_pkg;

   localparam int WORD_LENGTH  = `WORD_LENGTH;
   localparam int NUM_REGS     = 16;
   localparam int REG_ID_WIDTH = 4;
   localparam int NUM_RD_PORTS = 3;

   typedef logic [REG_ID_WIDTH-1:0] reg_id_t;

   localparam reg_id_t GR0_ID = 4'd0;

   // GR0 is hard-wired to zero and never participates in writes or reservations.
   function automatic logic is_gr0(input reg_id_t id);
      return (id == GR0_ID);
   endfunction

endpackage

// File: rtl/general_reg_file_if.sv
// Pipeline-to-register-file bus: three read ports, one writeback port, one
// reservation port and the scoreboard outputs.
interface general_reg_file_if #(
   parameter int WORD_LENGTH = general_reg_file_pkg::WORD_LENGTH,
   parameter int NUM_REGS    = general_reg_file_pkg::NUM_REGS
);
   import general_reg_file_pkg::reg_id_t;

   reg_id_t                 readRegIdA;
   reg_id_t                 readRegIdB;
   reg_id_t                 readRegIdX;
   logic                    readUseA;
   logic                    readUseB;
   logic                    readUseX;
   logic [WORD_LENGTH-1:0]  readRegA;
   logic [WORD_LENGTH-1:0]  readRegB;
   logic [WORD_LENGTH-1:0]  readRegX;

   logic                    wrEnable;
   reg_id_t                 wrRegId;
   logic [WORD_LENGTH-1:0]  wrVal;

   logic                    rsvEnable;
   reg_id_t                 rsvRegId;

   logic [NUM_REGS-1:0]     busyMask;
   logic                    stall;

   modport master (
      output readRegIdA, readRegIdB, readRegIdX,
      output readUseA, readUseB, readUseX,
      input  readRegA, readRegB, readRegX,
      output wrEnable, wrRegId, wrVal,
      output rsvEnable, rsvRegId,
      input  busyMask, stall
   );

   modport slave (
      input  readRegIdA, readRegIdB, readRegIdX,
      input  readUseA, readUseB, readUseX,
      output readRegA, readRegB, readRegX,
      input  wrEnable, wrRegId, wrVal,
      input  rsvEnable, rsvRegId,
      output busyMask, stall
   );

endinterface

// File: rtl/greg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, set by reservations,
// cleared by writebacks, and the resulting operand stall.
module greg_scoreboard
   import general_reg_file_pkg::*;
#(
   parameter int SB_NUM_REGS = NUM_REGS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  reg_id_t                       wr_id,
   input  logic                          rsv_en,
   input  reg_id_t                       rsv_id,
   input  reg_id_t [NUM_RD_PORTS-1:0]    rd_id,
   input  logic    [NUM_RD_PORTS-1:0]    rd_use,
   output logic    [SB_NUM_REGS-1:0]     busy_mask,
   output logic                          stall
);

   localparam logic [SB_NUM_REGS-1:0] BIT0   = {{(SB_NUM_REGS-1){1'b0}}, 1'b1};
   localparam logic [SB_NUM_REGS-1:0] NONE   = {SB_NUM_REGS{1'b0}};

   logic [SB_NUM_REGS-1:0] busy_r;
   logic [SB_NUM_REGS-1:0] clr_s;
   logic [SB_NUM_REGS-1:0] set_s;
   logic [SB_NUM_REGS-1:0] busy_nxt_s;
   logic                   stall_s;

   // Next busy state: clear on writeback, then set on reservation so a
   // same-cycle reserve of the written register leaves it pending.
   always_comb begin
      clr_s = NONE;
      set_s = NONE;
      if (wr_en) begin
         clr_s = BIT0 << wr_id;
      end else begin
         clr_s = NONE;
      end
      if (rsv_en && !is_gr0(rsv_id)) begin
         set_s = BIT0 << rsv_id;
      end else begin
         set_s = NONE;
      end
      busy_nxt_s = ((busy_r & ~clr_s) | set_s) & ~BIT0;
   end

   // Busy-bit register; reset discards every outstanding reservation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= NONE;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // A consumed operand stalls while pending, unless this cycle's writeback supplies it.
   always_comb begin
      stall_s = 1'b0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         if (rd_use[i] && busy_r[rd_id[i]] && !(wr_en && (wr_id == rd_id[i]))) begin
            stall_s = 1'b1;
         end else begin
            stall_s = stall_s;
         end
      end
   end

   assign busy_mask = busy_r;
   assign stall     = stall_s & rst;

endmodule

// File: rtl/general_reg_file.sv
// General register file GR0..GR15: three combinational read ports with
// writeback bypass, one write port, and a reservation scoreboard.
module general_reg_file #(
   parameter int WORD_LENGTH = general_reg_file_pkg::WORD_LENGTH,
   parameter int NUM_REGS    = general_reg_file_pkg::NUM_REGS
) (
   input  logic                 clk,
   input  logic                 rst,
   general_reg_file_if.slave    bus
);
   import general_reg_file_pkg::reg_id_t;
   import general_reg_file_pkg::is_gr0;
   import general_reg_file_pkg::NUM_RD_PORTS;

   localparam logic [WORD_LENGTH-1:0] ZERO_WORD = {WORD_LENGTH{1'b0}};

   logic [WORD_LENGTH-1:0]         gr_r [NUM_REGS];
   reg_id_t [NUM_RD_PORTS-1:0]     rd_id_s;
   logic    [NUM_RD_PORTS-1:0]     rd_use_s;
   logic [WORD_LENGTH-1:0]         rd_val_s [NUM_RD_PORTS];
   logic                           wr_ok_s;

   assign rd_id_s  = {bus.readRegIdX, bus.readRegIdB, bus.readRegIdA};
   assign rd_use_s = {bus.readUseX, bus.readUseB, bus.readUseA};
   assign wr_ok_s  = rst & bus.wrEnable & !is_gr0(bus.wrRegId);

   // Register storage; GR0 is never written so it stays at its reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            gr_r[i] <= ZERO_WORD;
         end
      end else if (wr_ok_s) begin
         gr_r[bus.wrRegId] <= bus.wrVal;
      end
   end

   // Read ports: GR0 reads zero, a same-cycle writeback is forwarded, else storage.
   always_comb begin
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         rd_val_s[i] = ZERO_WORD;
         if (is_gr0(rd_id_s[i])) begin
            rd_val_s[i] = ZERO_WORD;
         end else if (wr_ok_s && (bus.wrRegId == rd_id_s[i])) begin
            rd_val_s[i] = bus.wrVal;
         end else begin
            rd_val_s[i] = gr_r[rd_id_s[i]];
         end
      end
   end

   assign bus.readRegA = rd_val_s[0];
   assign bus.readRegB = rd_val_s[1];
   assign bus.readRegX = rd_val_s[2];

   greg_scoreboard #(
      .SB_NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_ok_s),
      .wr_id     (bus.wrRegId),
      .rsv_en    (bus.rsvEnable),
      .rsv_id    (bus.rsvRegId),
      .rd_id     (rd_id_s),
      .rd_use    (rd_use_s),
      .busy_mask (bus.busyMask),
      .stall     (bus.stall)
   );

endmodule

// File: tb/tb_general_reg_file.sv
// Directed bench for general_reg_file: expectations are queued as stimulus is
// driven and compared against the DUT outputs once they have settled.
module tb_general_reg_file;
   import general_reg_file_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   general_reg_file_if bus ();

   general_reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum int {K_RDA, K_RDB, K_RDX, K_BUSY, K_STALL} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic expect_val(input kind_e k, input logic [31:0] v, input string tag);
      exp_t e;
      e.kind = k;
      e.exp  = v;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   function automatic logic [31:0] observe(input kind_e k);
      case (k)
         K_RDA:   return bus.readRegA;
         K_RDB:   return bus.readRegB;
         K_RDX:   return bus.readRegX;
         K_BUSY:  return {16'h0000, bus.busyMask};
         K_STALL: return {31'h0, bus.stall};
         default: return 32'hxxxxxxxx;
      endcase
   endfunction

   // settle combinational outputs, then compare every queued expectation
   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observe(e.kind);
         checks++;
         assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic idle();
      bus.readRegIdA = 4'd0; bus.readRegIdB = 4'd0; bus.readRegIdX = 4'd0;
      bus.readUseA   = 1'b0; bus.readUseB   = 1'b0; bus.readUseX   = 1'b0;
      bus.wrEnable   = 1'b0; bus.wrRegId    = 4'd0; bus.wrVal      = 32'h0;
      bus.rsvEnable  = 1'b0; bus.rsvRegId   = 4'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      bus.readUseA = 1'b1; bus.readUseB = 1'b1; bus.readUseX = 1'b1;
      bus.readRegIdA = 4'd3;
      #3;
      expect_val(K_BUSY,  32'h0, "reset_busy");
      expect_val(K_STALL, 32'h0, "reset_stall");
      expect_val(K_RDA,   32'h0, "reset_rda");
      drain();
      #8 rst = 1'b1;

      // every id reads zero on all three ports after reset
      for (int i = 0; i < 16; i++) begin
         tick();
         bus.readRegIdA = 4'(i);
         bus.readRegIdB = 4'(15 - i);
         bus.readRegIdX = 4'((i + 5) % 16);
         expect_val(K_RDA,   32'h0, "clean_rda");
         expect_val(K_RDB,   32'h0, "clean_rdb");
         expect_val(K_RDX,   32'h0, "clean_rdx");
         expect_val(K_BUSY,  32'h0, "clean_busy");
         expect_val(K_STALL, 32'h0, "clean_stall");
         drain();
      end

      // write GR5 with same-cycle read
      tick(); idle();
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd5; bus.wrVal = 32'hDEADBEEF;
      bus.readRegIdA = 4'd5;
      expect_val(K_RDA, 32'hDEADBEEF, "gr5_bypass");
      drain();
      tick();
      bus.wrEnable = 1'b0;
      expect_val(K_RDA,  32'hDEADBEEF, "gr5_stored");
      expect_val(K_BUSY, 32'h0,        "gr5_busy");
      drain();

      // GR0 ignores write and reservation
      tick(); idle();
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd0; bus.wrVal = 32'h12345678;
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd0;
      bus.readRegIdB = 4'd0; bus.readUseB = 1'b1;
      expect_val(K_RDB,   32'h0, "gr0_bypass");
      expect_val(K_STALL, 32'h0, "gr0_stall");
      drain();
      tick(); idle();
      bus.readRegIdB = 4'd0; bus.readUseB = 1'b1;
      expect_val(K_RDB,   32'h0, "gr0_stored");
      expect_val(K_BUSY,  32'h0, "gr0_busy");
      expect_val(K_STALL, 32'h0, "gr0_stall_after");
      drain();

      // reserve GR3, stall on it, then resolve with a same-cycle writeback
      tick(); idle();
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd3;
      tick(); idle();
      bus.readRegIdX = 4'd3; bus.readUseX = 1'b1;
      expect_val(K_BUSY,  32'h0008, "gr3_busy_set");
      expect_val(K_STALL, 32'h1,    "gr3_stall");
      expect_val(K_RDX,   32'h0,    "gr3_old_val");
      drain();
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd3; bus.wrVal = 32'h55;
      expect_val(K_STALL, 32'h0,  "gr3_stall_bypass");
      expect_val(K_RDX,   32'h55, "gr3_rdx_bypass");
      drain();
      tick();
      bus.wrEnable = 1'b0;
      expect_val(K_BUSY,  32'h0,  "gr3_busy_clr");
      expect_val(K_RDX,   32'h55, "gr3_stored");
      expect_val(K_STALL, 32'h0,  "gr3_stall_after");
      drain();

      // same-cycle reserve and write of GR7: data stored, reservation wins
      tick(); idle();
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd7;
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd7; bus.wrVal = 32'hA5A5A5A5;
      bus.readRegIdA = 4'd7; bus.readUseA = 1'b1;
      expect_val(K_RDA,   32'hA5A5A5A5, "gr7_bypass");
      expect_val(K_STALL, 32'h0,        "gr7_stall_pre");
      drain();
      tick();
      bus.rsvEnable = 1'b0; bus.wrEnable = 1'b0;
      expect_val(K_BUSY,  32'h0080,     "gr7_busy");
      expect_val(K_RDA,   32'hA5A5A5A5, "gr7_stored");
      expect_val(K_STALL, 32'h1,        "gr7_stall");
      drain();

      // re-reserving a busy register keeps it busy
      tick(); idle();
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd7;
      tick(); idle();
      expect_val(K_BUSY, 32'h0080, "gr7_rereserve");
      drain();

      // write to a non-busy register, bypass on A and B independently
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd4; bus.wrVal = 32'h44;
      bus.readRegIdA = 4'd4; bus.readRegIdB = 4'd4; bus.readRegIdX = 4'd6;
      expect_val(K_RDA, 32'h44, "gr4_rda_bypass");
      expect_val(K_RDB, 32'h44, "gr4_rdb_bypass");
      expect_val(K_RDX, 32'h0,  "gr6_no_bypass");
      drain();
      tick();
      bus.wrEnable = 1'b0;
      expect_val(K_BUSY, 32'h0080, "gr4_busy_unchanged");
      expect_val(K_RDB,  32'h44,   "gr4_stored");
      drain();

      // writeback of GR7 releases it
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd7; bus.wrVal = 32'h7;
      tick(); idle();
      expect_val(K_BUSY, 32'h0, "gr7_released");
      drain();

      // reserve GR9 and write GR2, then reset mid-cycle
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd9;
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd2; bus.wrVal = 32'h1;
      tick(); idle();
      bus.readRegIdA = 4'd2;
      bus.readRegIdB = 4'd9; bus.readUseB = 1'b1;
      expect_val(K_BUSY,  32'h0200, "gr9_busy");
      expect_val(K_RDA,   32'h1,    "gr2_stored");
      expect_val(K_STALL, 32'h1,    "gr9_stall");
      drain();
      rst = 1'b0;
      expect_val(K_BUSY,  32'h0, "rst_busy");
      expect_val(K_RDA,   32'h0, "rst_gr2");
      expect_val(K_STALL, 32'h0, "rst_stall");
      drain();
      bus.wrEnable = 1'b1; bus.wrRegId = 4'd2; bus.wrVal = 32'h77;
      bus.rsvEnable = 1'b1; bus.rsvRegId = 4'd5;
      expect_val(K_RDA, 32'h0, "rst_no_bypass");
      drain();
      tick();
      expect_val(K_BUSY, 32'h0, "rst_rsv_ignored");
      expect_val(K_RDA,  32'h0, "rst_wr_ignored");
      drain();
      idle();
      rst = 1'b1;
      tick();
      bus.readRegIdA = 4'd9; bus.readUseA = 1'b1;
      expect_val(K_STALL, 32'h0, "post_rst_stall");
      expect_val(K_BUSY,  32'h0, "post_rst_busy");
      expect_val(K_RDA,   32'h0, "post_rst_gr9");
      drain();
      tick();
      bus.readRegIdA = 4'd2;
      expect_val(K_RDA, 32'h0, "post_rst_gr2");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
